// File: rtl/bitblaster_pkg.sv
// Shared BitBlaster definitions: sequencer states, timestep and opcode
// constants, and the instruction legality decode used by sequencer and controller.
package bitblaster_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } seq_state_t;

    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] T3 = 2'b11;

    // Register-form opcodes live in INST[3:0] under PFX_REG; ADDI/SUBI are prefix-coded.
    localparam logic [3:0] OP_LOAD = 4'h0;
    localparam logic [3:0] OP_COPY = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_DEC  = 4'hB;
    localparam logic [3:0] OP_LAST_REG = OP_DEC;

    localparam logic [1:0] PFX_REG  = 2'b00;
    localparam logic [1:0] PFX_ADDI = 2'b10;
    localparam logic [1:0] PFX_SUBI = 2'b11;

    function automatic logic is_legal(input logic [9:0] inst);
        logic ok;
        ok = 1'b0;
        case (inst[9:8])
            PFX_REG:            ok = (inst[3:0] <= OP_LAST_REG);
            PFX_ADDI, PFX_SUBI: ok = 1'b1;
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// BitBlaster timestep sequencer and instruction register, with illegal-encoding
// and runaway detection plus a retired-instruction counter.
module instr_sequencer
    import bitblaster_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exec,
    input  logic             step_mode,
    input  logic [9:0]       data_in,
    input  logic             irin,
    input  logic             clr,
    output logic [1:0]       T,
    output logic [9:0]       IR,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    seq_state_t       state_q, state_d;
    logic [1:0]       t_q, t_d;
    logic [9:0]       ir_q, ir_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            t_q       <= T0;
            ir_q      <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            ir_q      <= ir_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        // In free-run, EXEC advances every cycle and any exec pulse there is dropped.
        adv       = step_mode ? exec : ((state_q == EXEC) ? 1'b1 : exec);
        state_d   = state_q;
        t_d       = t_q;
        ir_d      = ir_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        retired_d = retired_q;

        case (state_q)
            IDLE: begin
                if (adv && irin) begin
                    ir_d = data_in;
                    if (is_legal(data_in)) begin
                        state_d   = EXEC;
                        t_d       = T1;
                        illegal_d = 1'b0;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (adv) begin
                    if (clr) begin
                        state_d   = IDLE;
                        t_d       = T0;
                        done_d    = 1'b1;
                        retired_d = retired_q + CNT_W'(1);
                    end else if (t_q != T3) begin
                        t_d = t_q + 2'd1;
                    end else begin
                        // Controller never ended the instruction: abort as runaway.
                        state_d   = IDLE;
                        t_d       = T0;
                        illegal_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                t_d     = T0;
            end
        endcase
    end

    assign T       = t_q;
    assign IR      = ir_q;
    assign busy    = (state_q == EXEC);
    assign done    = done_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected instruction
// outcomes, a negedge monitor pops and compares them when the DUT ends an instruction.
module tb_instr_sequencer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             exec = 1'b0;
    logic             step_mode = 1'b0;
    logic [9:0]       data_in = '0;
    logic             irin = 1'b0;
    logic             clr_en = 1'b0;
    logic [1:0]       clr_t = 2'd0;
    logic             clr;
    logic [1:0]       T;
    logic [9:0]       IR;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    // Controller stand-in: ends the instruction when the timestep reaches clr_t.
    assign clr = clr_en && (T == clr_t);

    always #5 clk = ~clk;

    instr_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .exec      (exec),
        .step_mode (step_mode),
        .data_in   (data_in),
        .irin      (irin),
        .clr       (clr),
        .T         (T),
        .IR        (IR),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .retired   (retired)
    );

    typedef enum int {EV_RETIRE = 0, EV_RUNAWAY = 1, EV_ILLEGAL = 2} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic [9:0] ir;
        int         ret;
        int         blen;
        int         tsum;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   m_illegal = 1'b0;
    int   m_ret_count = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_legal(input logic [9:0] w);
        int p;
        int op;
        p  = int'(w) / 256;
        op = int'(w) % 16;
        return (p == 2) || (p == 3) || (p == 0 && op < 12);
    endfunction

    task automatic handle_event(input ev_kind_t k, input int blen, input int tsum);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", int'(k), cyc);
        end else begin
            e = q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            check("event_cycle", cyc, e.cyc);
            check("IR", int'(IR), int'(e.ir));
            check("retired", int'(retired), e.ret);
            check("busy_cycles", blen, e.blen);
            check("T_sum", tsum, e.tsum);
            check("illegal", int'(illegal), (e.kind == EV_RETIRE) ? 0 : 1);
            check("T_after", int'(T), 0);
        end
    endtask

    // Monitor
    initial begin
        bit pb;
        bit pd;
        bit pi;
        int blen;
        int tsum;
        pb = 1'b0; pd = 1'b0; pi = 1'b0; blen = 0; tsum = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b0; pd = 1'b0; pi = 1'b0; blen = 0; tsum = 0;
            end else begin
                if (pd) check("done_one_cycle", int'(done), 0);
                if (busy) begin
                    blen++;
                    tsum += int'(T);
                end
                if (done) begin
                    handle_event(EV_RETIRE, blen, tsum);
                    blen = 0; tsum = 0;
                end else if (pb && !busy) begin
                    handle_event(EV_RUNAWAY, blen, tsum);
                    blen = 0; tsum = 0;
                end else if (!pb && !busy && illegal && !pi) begin
                    handle_event(EV_ILLEGAL, blen, tsum);
                    blen = 0; tsum = 0;
                end
                pb = busy;
                pd = done;
                pi = illegal;
            end
        end
    end

    // clr_at: timestep at which the controller ends the instruction (0 = never).
    task automatic issue(input logic [9:0] word, input bit smode, input int clr_at, input int gap);
        int   n;
        int   ev;
        int   ns;
        int   g;
        exp_t e;
        g         = smode ? gap : 0;
        step_mode = smode;
        data_in   = word;
        irin      = 1'b1;
        exec      = 1'b1;
        clr_t     = 2'(clr_at);
        clr_en    = (clr_at != 0);
        n         = cyc;
        e.ir      = word;
        if (!ref_legal(word)) begin
            m_illegal = 1'b1;
            e.kind = EV_ILLEGAL; e.cyc = n + 1; e.blen = 0; e.tsum = 0;
            e.ret  = m_ret_count % (1 << CNT_W);
            q.push_back(e);
            tick();
            exec = 1'b0;
            irin = 1'b0;
            return;
        end
        ns     = (clr_at == 0) ? 3 : clr_at;
        e.blen = ns * (g + 1);
        e.tsum = (g + 1) * ns * (ns + 1) / 2;
        ev     = n + ns * (g + 1) + 1;
        e.cyc  = ev;
        if (clr_at == 0) begin
            e.kind    = EV_RUNAWAY;
            m_illegal = 1'b1;
        end else begin
            e.kind    = EV_RETIRE;
            m_illegal = 1'b0;
            m_ret_count++;
        end
        e.ret = m_ret_count % (1 << CNT_W);
        q.push_back(e);
        tick();
        while (cyc < ev) begin
            exec    = smode ? (((cyc - n) % (g + 1)) == 0) : 1'($urandom);
            irin    = 1'($urandom);
            data_in = 10'($urandom);
            tick();
        end
        exec   = 1'b0;
        irin   = 1'b0;
        clr_en = 1'b0;
    endtask

    initial begin
        logic [9:0] w;
        bit         sm;
        int         ca;
        int         gp;

        repeat (3) tick();
        check("rst_T", int'(T), 0);
        check("rst_IR", int'(IR), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_retired", int'(retired), 0);
        rst_n = 1'b1;
        tick();

        issue(10'b00_01_10_0010, 1'b0, 3, 0);   // free-run add
        issue(10'b00_10_00_0000, 1'b0, 1, 0);   // free-run ld
        issue(10'b10_00_000101, 1'b1, 3, 5);    // step-mode addi with idle gaps
        issue(10'b01_00_000000, 1'b0, 1, 0);    // illegal prefix
        issue(10'b11_00_000011, 1'b0, 3, 0);    // legal fetch clears illegal
        issue(10'b00_00_00_1101, 1'b0, 1, 0);   // illegal register opcode
        issue(10'b00_01_10_0010, 1'b0, 0, 0);   // runaway
        issue(10'b00_01_00_0011, 1'b1, 0, 2);   // runaway in step mode

        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) begin
                exec    = 1'b0;
                irin    = 1'($urandom);
                data_in = 10'($urandom);
                tick();
            end
            if ($urandom_range(0, 7) == 0) begin
                exec    = 1'b1;
                irin    = 1'b0;
                data_in = 10'($urandom);
                tick();
                exec = 1'b0;
            end
            w = 10'($urandom);
            if (!ref_legal(w) && m_illegal) w[9:8] = 2'b10;
            sm = 1'($urandom);
            ca = $urandom_range(0, 3);
            gp = $urandom_range(0, 3);
            issue(w, sm, ca, gp);
        end

        // Reset in the middle of an addi, at T=10.
        tick();
        step_mode = 1'b0;
        data_in   = 10'b10_00_000111;
        irin      = 1'b1;
        exec      = 1'b1;
        clr_t     = 2'd3;
        clr_en    = 1'b1;
        tick();
        exec = 1'b0;
        irin = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_T", int'(T), 0);
        check("midrst_IR", int'(IR), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_illegal", int'(illegal), 0);
        check("midrst_retired", int'(retired), 0);
        clr_en      = 1'b0;
        m_illegal   = 1'b0;
        m_ret_count = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Counter wrap: 2^CNT_W retires brings retired back to zero.
        for (int i = 0; i < (1 << CNT_W); i++) begin
            issue(10'b00_10_00_0000, 1'b0, 1, 0);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
